// File: rtl/theta_update_scheduler.sv
// Round-robin scheduler that shares the theta accumulator datapath between N_REQ delta sources.
// Optional idle watchdog output `stale` is built only when THETA_SCHED_STALE_EN is defined.
module theta_update_scheduler #(
    parameter int          N_REQ        = 4,
    parameter longint      TWO_PI_MICRO = 64'sd6283185,
    parameter int unsigned STALE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*64-1:0] delta_in,
    output logic [N_REQ-1:0]   ack,
    output logic               soma,
    output logic               normaliza,
    output logic [63:0]        delta_theta,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic               err_range,
    output logic [15:0]        update_cnt
`ifdef THETA_SCHED_STALE_EN
    ,
    output logic               stale
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SOMA  = 3'd2,
        NORM1 = 3'd3,
        NORM2 = 3'd4,
        ACK   = 3'd5
    } state_t;

    localparam logic [2:0] LAST_ID = 3'(N_REQ - 1);

    state_t      state, state_nx;
    logic [2:0]  ptr;
    logic [2:0]  pick;
    logic        any_req;
    logic        accepted;
    logic        in_range;
    int unsigned idx;

    // Scan upward from ptr with wrap; the first pending source wins.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr) + i) % 32'(N_REQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = idx[2:0];
            end
        end
    end

    assign in_range = ($signed(delta_theta) > -TWO_PI_MICRO) &&
                      ($signed(delta_theta) <  TWO_PI_MICRO);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = LOAD;
            LOAD:    state_nx = in_range ? SOMA : ACK;
            SOMA:    state_nx = NORM1;
            NORM1:   state_nx = NORM2;
            NORM2:   state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are registered from the current state, so each appears one cycle after its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            grant_id    <= '0;
            delta_theta <= '0;
            accepted    <= 1'b0;
            update_cnt  <= '0;
            soma        <= 1'b0;
            normaliza   <= 1'b0;
            err_range   <= 1'b0;
            ack         <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_id    <= pick;
                delta_theta <= delta_in[{pick, 6'b0} +: 64];
            end
            if (state == LOAD) accepted <= in_range;
            if (state == ACK) begin
                ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 3'd1;
                if (accepted) update_cnt <= update_cnt + 16'd1;
            end
            soma      <= (state == SOMA);
            normaliza <= (state == NORM1) || (state == NORM2);
            err_range <= (state == ACK) && !accepted;
            for (int unsigned i = 0; i < N_REQ; i++)
                ack[i] <= (state == ACK) && (grant_id == 3'(i));
        end
    end

`ifdef THETA_SCHED_STALE_EN
    logic [31:0] idle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          idle_cnt <= '0;
        else if (state == ACK && accepted)  idle_cnt <= '0;
        else if (idle_cnt != '1)            idle_cnt <= idle_cnt + 32'd1;
    end

    assign stale = (idle_cnt >= STALE_CYCLES);
`endif

endmodule
